// File: rtl/shift_register_param.sv
// Parametrised WIDTH x DEPTH shift register with shift, rotate, parallel load and fill flag.
// Latency: ser_in reaches ser_out after DEPTH shifting edges; a load is visible one cycle later.
// Backpressure: none; en low (or mode hold) freezes every stage and the fill count.
module shift_register_param #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       ser_in,
  input  logic [WIDTH*DEPTH-1:0] par_in,
  output logic [WIDTH-1:0]       ser_out,
  output logic [WIDTH*DEPTH-1:0] par_out,
  output logic                   filled
);

  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  // Packed so that element i lands on bits [WIDTH*(i+1)-1 : WIDTH*i], matching par_in/par_out.
  logic [DEPTH-1:0][WIDTH-1:0] stage;
  logic [DEPTH-1:0][WIDTH-1:0] stage_nxt;
  logic [CW-1:0]               cnt;
  logic [CW-1:0]               cnt_nxt;

  // Next-state decode: every stage is built from pre-edge values only.
  always_comb begin
    stage_nxt = stage;
    cnt_nxt   = cnt;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          stage_nxt = stage;
        end
        MODE_SHIFT: begin
          stage_nxt = {stage[DEPTH-2:0], ser_in};
          // Fill count saturates at DEPTH so filled never drops while shifting.
          if (cnt != CW'(DEPTH)) begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        MODE_ROTATE: begin
          stage_nxt = {stage[DEPTH-2:0], stage[DEPTH-1]};
        end
        MODE_LOAD: begin
          stage_nxt = par_in;
          cnt_nxt   = CW'(DEPTH);
        end
        default: begin
          stage_nxt = stage;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset that overrides en and mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage <= '0;
      cnt   <= '0;
    end else begin
      stage <= stage_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign ser_out = stage[DEPTH-1];
  assign par_out = stage;
  assign filled  = (cnt == CW'(DEPTH));

endmodule

// File: tb/tb_shift_register_param.sv
// Bench for shift_register_param: three instances (1x3, 8x4, 4x4) share control signals,
// a word-array reference model feeds a scoreboard queue, and a monitor checks every cycle.
// Directed phases follow the reset/delay/enable/load-rotate/hold scenarios, then random traffic.
module tb_shift_register_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [1:0]  mode = 2'b01;
  logic [0:0]  ser_a = '0;
  logic [2:0]  par_in_a = '0;
  logic [7:0]  ser_b = '0;
  logic [31:0] par_in_b = '0;
  logic [3:0]  ser_c = '0;
  logic [15:0] par_in_c = '0;

  logic [0:0]  sout_a;
  logic [2:0]  pout_a;
  logic        fil_a;
  logic [7:0]  sout_b;
  logic [31:0] pout_b;
  logic        fil_b;
  logic [3:0]  sout_c;
  logic [15:0] pout_c;
  logic        fil_c;

  always #5 clk = ~clk;

  shift_register_param dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ser_in(ser_a), .par_in(par_in_a),
    .ser_out(sout_a), .par_out(pout_a), .filled(fil_a));

  shift_register_param #(.WIDTH(8), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ser_in(ser_b), .par_in(par_in_b),
    .ser_out(sout_b), .par_out(pout_b), .filled(fil_b));

  shift_register_param #(.WIDTH(4), .DEPTH(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ser_in(ser_c), .par_in(par_in_c),
    .ser_out(sout_c), .par_out(pout_c), .filled(fil_c));

  int checks = 0;
  int failures = 0;

  // Reference model: each instance is a list of words plus a fill counter.
  int          wd [3] = '{1, 8, 4};
  int          dp [3] = '{3, 4, 4};
  longint unsigned st [3][4];
  int          cnt [3];

  typedef struct {
    logic [2:0]  pa;
    logic [31:0] pb;
    logic [15:0] pc;
    logic [2:0]  fil;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned pack(input int k);
    longint unsigned r = 0;
    for (int i = 0; i < dp[k]; i++) r |= st[k][i] << (wd[k] * i);
    return r;
  endfunction

  task automatic model_update(input int k, input longint unsigned si, input longint unsigned pi);
    longint unsigned mask = (64'd1 << wd[k]) - 1;
    longint unsigned last;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) st[k][i] = 0;
      cnt[k] = 0;
    end else if (en) begin
      case (mode)
        2'b01, 2'b10: begin
          last = st[k][dp[k]-1];
          for (int i = dp[k] - 1; i > 0; i--) st[k][i] = st[k][i-1];
          st[k][0] = (mode == 2'b01) ? (si & mask) : last;
          if (mode == 2'b01 && cnt[k] < dp[k]) cnt[k]++;
        end
        2'b11: begin
          for (int i = 0; i < dp[k]; i++) st[k][i] = (pi >> (wd[k] * i)) & mask;
          cnt[k] = dp[k];
        end
        default: ;
      endcase
    end
  endtask

  // Apply current inputs for one edge: update the model, queue the expected response, step the clock.
  task automatic tick();
    exp_t e;
    model_update(0, 64'(ser_a), 64'(par_in_a));
    model_update(1, 64'(ser_b), 64'(par_in_b));
    model_update(2, 64'(ser_c), 64'(par_in_c));
    e.pa = 3'(pack(0));
    e.pb = 32'(pack(1));
    e.pc = 16'(pack(2));
    for (int k = 0; k < 3; k++) e.fil[k] = (cnt[k] == dp[k]);
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per edge, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_par_a", 64'(pout_a), 64'(e.pa));
        chk("sb_ser_a", 64'(sout_a), 64'(e.pa[2]));
        chk("sb_fil_a", 64'(fil_a), 64'(e.fil[0]));
        chk("sb_par_b", 64'(pout_b), 64'(e.pb));
        chk("sb_ser_b", 64'(sout_b), 64'(e.pb[31:24]));
        chk("sb_fil_b", 64'(fil_b), 64'(e.fil[1]));
        chk("sb_par_c", 64'(pout_c), 64'(e.pc));
        chk("sb_ser_c", 64'(sout_c), 64'(e.pc[15:12]));
        chk("sb_fil_c", 64'(fil_c), 64'(e.fil[2]));
      end
    end
  end

  initial begin
    logic [15:0] snap_c;
    logic [0:0]  seq_a [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [0:0]  exp_sa [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Reset held for two edges while shifting ones.
    rst_n = 1'b0; en = 1'b1; mode = 2'b01; ser_a = 1'b1; ser_b = 8'hFF; ser_c = 4'hF;
    tick(); tick();
    chk("rst_par_a", 64'(pout_a), 64'h0);
    chk("rst_ser_a", 64'(sout_a), 64'h0);
    chk("rst_fil_a", 64'(fil_a), 64'h0);

    // Serial delay on the default 1x3 instance: ser_out after edges 3..6.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ser_a = (i < 4) ? seq_a[i] : 1'b0;
      tick();
      if (i == 1) chk("delay_fil_early", 64'(fil_a), 64'h0);
      if (i == 2) chk("delay_fil_edge3", 64'(fil_a), 64'h1);
      if (i >= 2) chk("delay_ser_out", 64'(sout_a), 64'(exp_sa[i-2]));
    end

    // Enable gating on the 8x4 instance; 0xFF offered while disabled must never enter.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    ser_b = 8'h11; tick();
    ser_b = 8'h22; tick();
    en = 1'b0; ser_b = 8'hFF; repeat (3) tick();
    en = 1'b1;
    ser_b = 8'h33; tick();
    ser_b = 8'h44; tick();
    chk("en_gate_par_b", 64'(pout_b), 64'h11223344);
    chk("en_gate_fil_b", 64'(fil_b), 64'h1);

    // Load then rotate on the 4x4 instance.
    mode = 2'b11; par_in_c = 16'hA5C3; par_in_b = $urandom; par_in_a = 3'b101; tick();
    chk("load_ser_c", 64'(sout_c), 64'hA);
    chk("load_fil_c", 64'(fil_c), 64'h1);
    mode = 2'b10; tick();
    chk("rot1_par_c", 64'(pout_c), 64'h5C3A);
    repeat (3) tick();
    chk("rot4_par_c", 64'(pout_c), 64'hA5C3);

    // Synchronous reset mid-stream with shift requested, then refill.
    rst_n = 1'b0; mode = 2'b01; ser_c = 4'h7; tick();
    chk("mrst_par_c", 64'(pout_c), 64'h0);
    chk("mrst_fil_c", 64'(fil_c), 64'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ser_c = 4'($urandom);
      tick();
      chk("refill_fil_c", 64'(fil_c), (i == 3) ? 64'h1 : 64'h0);
    end

    // Hold mode with toggling ser_in: contents and fill state frozen.
    snap_c = 16'(pack(2));
    mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      ser_c = (i % 2 == 0) ? 4'hF : 4'h0;
      ser_a = 1'(i);
      tick();
    end
    chk("hold_par_c", 64'(pout_c), 64'(snap_c));
    chk("hold_fil_c", 64'(fil_c), 64'h1);

    // Randomised traffic including occasional resets and enable drops.
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 39) != 0);
      en       = ($urandom_range(0, 3) != 0);
      mode     = 2'($urandom);
      ser_a    = 1'($urandom);
      ser_b    = 8'($urandom);
      ser_c    = 4'($urandom);
      par_in_a = 3'($urandom);
      par_in_b = $urandom;
      par_in_c = 16'($urandom);
      tick();
    end

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sbq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
